// File: rtl/gpio_input_debounce_if.sv
// -----------------------------------------------------------------------------
// gpio_input_debounce_if
// Bundles the pad-side inputs and the conditioned outputs of the GPIO input
// debounce stage.
//   en_i        : 1 = filtering active, 0 = bypass
//   pins_i      : raw asynchronous pad levels
//   debounced_o : filtered levels feeding the GPIO input bus
//   rise_o      : one-cycle pulse per channel on a 0->1 debounced transition
//   fall_o      : one-cycle pulse per channel on a 1->0 debounced transition
//   any_edge_o  : OR of all rise/fall pulses, aligned with them
// master = block that drives the pads (test harness / pad ring),
// slave  = the debounce stage itself.
// -----------------------------------------------------------------------------
interface gpio_input_debounce_if #(
   parameter int WIDTH = 16
);
   logic             en_i;
   logic [WIDTH-1:0] pins_i;
   logic [WIDTH-1:0] debounced_o;
   logic [WIDTH-1:0] rise_o;
   logic [WIDTH-1:0] fall_o;
   logic             any_edge_o;

   modport master (
      output en_i, pins_i,
      input  debounced_o, rise_o, fall_o, any_edge_o
   );

   modport slave (
      input  en_i, pins_i,
      output debounced_o, rise_o, fall_o, any_edge_o
   );
endinterface

// File: rtl/gpio_input_debounce.sv
// -----------------------------------------------------------------------------
// gpio_input_debounce
// Input conditioning between the GPIO pads and the GPIO input port: each pad
// bit is synchronised into clk_i, filtered by a per-channel stability counter
// and presented as a clean level plus registered rise/fall event pulses.
// Ports:
//   clk_i : system clock
//   rst_i : synchronous, active-high reset
//   bus   : gpio_input_debounce_if.slave (en_i, pins_i in; debounced_o,
//           rise_o, fall_o, any_edge_o out)
// A channel's debounced level follows its synchronised level only after the
// two have differed for DEBOUNCE_CYCLES consecutive edges; any agreement in
// between restarts qualification. With en_i=0 the synchronised level passes
// straight through and counters are held at zero.
// -----------------------------------------------------------------------------
module gpio_input_debounce #(
   parameter int WIDTH           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int CNT_W           = 10
) (
   input logic                    clk_i,
   input logic                    rst_i,
   gpio_input_debounce_if.slave   bus
);

   // Count value at which a differing level is accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchroniser chain: index 0 samples the pads, index SYNC_STAGES-1 is the
   // metastability-safe level used by the filter.
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  sync;

   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]            deb_q, deb_d;
   logic [WIDTH-1:0]            rise_q, rise_d;
   logic [WIDTH-1:0]            fall_q, fall_d;
   logic                        any_q, any_d;

   assign sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so
      // no path leaves a value unassigned and no latch is inferred.
      deb_d = deb_q;
      cnt_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!bus.en_i) begin
            // Bypass: take the synchronised level now; counters stay at 0.
            deb_d[i] = sync[i];
         end else if (sync[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = sync[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
         // Agreement with the debounced level leaves cnt_d at its 0 default,
         // which is what restarts qualification after a bounce.
      end
      // Pulses are derived from the accepted transition so they line up with
      // the debounced_o change in the following cycle.
      rise_d = deb_d & ~deb_q;
      fall_d = ~deb_d & deb_q;
      any_d  = |(rise_d | fall_d);
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // this block samples the pre-edge values of the others.
      if (rst_i) begin
         sync_q <= '0;
         cnt_q  <= '0;
         deb_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         any_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pins_i};
         cnt_q  <= cnt_d;
         deb_q  <= deb_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         any_q  <= any_d;
      end
   end

   assign bus.debounced_o = deb_q;
   assign bus.rise_o      = rise_q;
   assign bus.fall_o      = fall_q;
   assign bus.any_edge_o  = any_q;

endmodule
